// File: rtl/xswitch_pkg.sv
// Shared types and default widths for the xswitch ingress path.
package xswitch_pkg;

    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned NUM_PORTS = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } xsw_word_t;

    typedef enum logic {
        IDLE,
        SEND
    } ingress_state_t;

endpackage

// File: rtl/xswitch_sync_fifo.sv
// Single-clock FIFO: storage, wrapping pointers, occupancy and full/empty flags.
module xswitch_sync_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = PtrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [LvlW-1:0]  level_q, level_d;

    always_comb begin
        level_d = level_q;
        unique case ({push_i, pop_i})
            2'b10:   level_d = level_q + LvlW'(1);
            2'b01:   level_d = level_q - LvlW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    // Pointers are exactly log2(DEPTH) bits so they wrap with no extra logic.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (push_i) begin
                wptr_q <= wptr_q + PtrW'(1);
            end
            if (pop_i) begin
                rptr_q <= rptr_q + PtrW'(1);
            end
            level_q <= level_d;
        end
    end

    assign rdata_o = mem_q[rptr_q];
    assign full_o  = (level_q == LvlW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;

endmodule

// File: rtl/xswitch_ingress_queue.sv
// Per-port ingress queue feeding one xswitch input with overflow/stall flags.
// Optional sent-word counter is built when XSWITCH_INGRESS_STATS_EN is defined.
module xswitch_ingress_queue #(
    parameter int unsigned ADDR_W    = xswitch_pkg::ADDR_W,
    parameter int unsigned DATA_W    = xswitch_pkg::DATA_W,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned STALL_MAX = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [ADDR_W-1:0]        addr_in,
    output logic [DATA_W-1:0]        data_in,
    output logic                     valid_in,
    input  logic                     rcv_rdy,
    output logic                     overflow,
    output logic                     stall_err,
    input  logic                     clr_err,
    output logic [15:0]              sent_count
);

    import xswitch_pkg::*;

    localparam int unsigned WordW = ADDR_W + DATA_W;
    localparam int unsigned CntW  = $clog2(STALL_MAX + 1);
    localparam logic [CntW-1:0] StallLast = CntW'(STALL_MAX - 1);
    localparam logic [CntW-1:0] StallSat  = CntW'(STALL_MAX);

    ingress_state_t    state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              overflow_q;
    logic              stall_q;
    logic [CntW-1:0]   stall_cnt_q;

    logic              push, pop, xfer, stalling, stall_set;
    logic [WordW-1:0]  head;

    // full is the pre-edge value, so a push while full is dropped even if a pop frees space.
    assign push     = wr_en & ~full;
    assign xfer     = valid_q & rcv_rdy;
    assign stalling = (state_q == SEND) & ~rcv_rdy;
    assign stall_set = stalling & (stall_cnt_q >= StallLast);

    always_comb begin
        pop = 1'b0;
        unique case (state_q)
            IDLE:    pop = ~empty;
            SEND:    pop = xfer & ~empty;
            default: pop = 1'b0;
        endcase
    end

    xswitch_sync_fifo #(
        .WIDTH (WordW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({wr_addr, wr_data}),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pop) begin
                        state_q          <= SEND;
                        valid_q          <= 1'b1;
                        {addr_q, data_q} <= head;
                    end
                end
                SEND: begin
                    if (xfer) begin
                        if (pop) begin
                            {addr_q, data_q} <= head;
                        end else begin
                            state_q <= IDLE;
                            valid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    // A set condition on the same edge as clr_err takes priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            stall_q     <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (stalling) begin
                if (stall_cnt_q != StallSat) begin
                    stall_cnt_q <= stall_cnt_q + CntW'(1);
                end
            end else begin
                stall_cnt_q <= '0;
            end
            stall_q    <= stall_set | (stall_q & ~clr_err);
            overflow_q <= (wr_en & full) | (overflow_q & ~clr_err);
        end
    end

`ifdef XSWITCH_INGRESS_STATS_EN
    logic [15:0] sent_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sent_q <= '0;
        end else if (xfer) begin
            sent_q <= sent_q + 16'd1;
        end
    end

    assign sent_count = sent_q;
`else
    assign sent_count = '0;
`endif

    assign addr_in   = addr_q;
    assign data_in   = data_q;
    assign valid_in  = valid_q;
    assign overflow  = overflow_q;
    assign stall_err = stall_q;

endmodule

// File: tb/tb_xswitch_ingress_queue.sv
// Directed bench for xswitch_ingress_queue (DEPTH=8, STALL_MAX=64).
module tb_xswitch_ingress_queue;

    logic        clk = 1'b0;
    logic        reset, wr_en, rcv_rdy, clr_err;
    logic [7:0]  wr_addr, wr_data;
    logic        full, empty, valid_in, overflow, stall_err;
    logic [3:0]  level;
    logic [7:0]  addr_in, data_in;
    logic [15:0] sent_count;

    int n_cmp  = 0;
    int n_fail = 0;

`ifdef XSWITCH_INGRESS_STATS_EN
    localparam bit Stats = 1'b1;
`else
    localparam bit Stats = 1'b0;
`endif

    always #5 clk = ~clk;

    xswitch_ingress_queue #(
        .ADDR_W    (8),
        .DATA_W    (8),
        .DEPTH     (8),
        .STALL_MAX (64)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .full       (full),
        .empty      (empty),
        .level      (level),
        .addr_in    (addr_in),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .rcv_rdy    (rcv_rdy),
        .overflow   (overflow),
        .stall_err  (stall_err),
        .clr_err    (clr_err),
        .sent_count (sent_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        wr_en   = 1'b0;
        rcv_rdy = 1'b0;
        clr_err = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".valid"},    32'(valid_in),   32'd0);
        check({tag, ".addr"},     32'(addr_in),    32'd0);
        check({tag, ".data"},     32'(data_in),    32'd0);
        check({tag, ".level"},    32'(level),      32'd0);
        check({tag, ".empty"},    32'(empty),      32'd1);
        check({tag, ".full"},     32'(full),       32'd0);
        check({tag, ".overflow"}, 32'(overflow),   32'd0);
        check({tag, ".stall"},    32'(stall_err),  32'd0);
        check({tag, ".sent"},     32'(sent_count), 32'd0);
    endtask

    initial begin
        // Reset values
        reset = 1'b1;
        do_reset();
        tick();
        check_reset_state("rst");

        // Single word: push at edge 1, presented after edge 2, accepted at edge 3
        wr_en = 1'b1; wr_addr = 8'h02; wr_data = 8'hA5;
        tick();
        wr_en = 1'b0;
        check("single.lvl1",   32'(level),    32'd1);
        check("single.v_pre",  32'(valid_in), 32'd0);
        tick();
        check("single.valid",  32'(valid_in), 32'd1);
        check("single.addr",   32'(addr_in),  32'h02);
        check("single.data",   32'(data_in),  32'hA5);
        check("single.empty",  32'(empty),    32'd1);
        rcv_rdy = 1'b1;
        tick();
        rcv_rdy = 1'b0;
        check("single.v_done", 32'(valid_in), 32'd0);
        check("single.e_done", 32'(empty),    32'd1);
        check("single.sent",   32'(sent_count), Stats ? 32'd1 : 32'd0);

        // Back-to-back: data 0x10..0x17 with rcv_rdy held high, no bubbles
        do_reset();
        rcv_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_addr = 8'(8'h80 + i); wr_data = 8'(8'h10 + i);
            tick();
            if (i > 0) begin
                check("b2b.valid", 32'(valid_in), 32'd1);
                check("b2b.data",  32'(data_in),  32'(8'h10 + i - 1));
                check("b2b.level", 32'(level),    32'd1);
            end
        end
        wr_en = 1'b0;
        tick();
        check("b2b.valid7", 32'(valid_in), 32'd1);
        check("b2b.data7",  32'(data_in),  32'h17);
        check("b2b.addr7",  32'(addr_in),  32'h87);
        tick();
        rcv_rdy = 1'b0;
        check("b2b.idle", 32'(valid_in),   32'd0);
        check("b2b.sent", 32'(sent_count), Stats ? 32'd8 : 32'd0);

        // Fill and overflow: 10 pushes, one in output reg + 8 queued, 10th dropped
        do_reset();
        for (int i = 0; i < 10; i++) begin
            wr_en = 1'b1; wr_addr = 8'(i); wr_data = 8'(8'h20 + i);
            tick();
        end
        wr_en = 1'b0;
        check("fill.level", 32'(level),    32'd8);
        check("fill.full",  32'(full),     32'd1);
        check("fill.ovf",   32'(overflow), 32'd1);
        check("fill.data",  32'(data_in),  32'h20);
        rcv_rdy = 1'b1;
        for (int j = 0; j < 9; j++) begin
            check("drain.valid", 32'(valid_in), 32'd1);
            check("drain.data",  32'(data_in),  32'(8'h20 + j));
            tick();
        end
        rcv_rdy = 1'b0;
        check("drain.done",  32'(valid_in), 32'd0);
        check("drain.empty", 32'(empty),    32'd1);
        check("drain.ovf",   32'(overflow), 32'd1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("ovf.clr", 32'(overflow), 32'd0);

        // Push while full with simultaneous transfer: push still dropped
        do_reset();
        for (int i = 0; i < 9; i++) begin
            wr_en = 1'b1; wr_addr = 8'(i); wr_data = 8'(8'h30 + i);
            tick();
        end
        check("pwf.level8", 32'(level),    32'd8);
        check("pwf.ovf0",   32'(overflow), 32'd0);
        wr_data = 8'h99; rcv_rdy = 1'b1;
        tick();
        wr_en = 1'b0;
        check("pwf.level7", 32'(level),    32'd7);
        check("pwf.ovf1",   32'(overflow), 32'd1);
        check("pwf.full",   32'(full),     32'd0);
        for (int j = 1; j < 9; j++) begin
            check("pwf.drain", 32'(data_in), 32'(8'h30 + j));
            tick();
        end
        rcv_rdy = 1'b0;
        check("pwf.done", 32'(valid_in), 32'd0);

        // Stall: valid held 64 edges without rcv_rdy
        do_reset();
        wr_en = 1'b1; wr_addr = 8'h40; wr_data = 8'h41;
        tick();
        wr_en = 1'b0;
        tick();
        check("stall.valid", 32'(valid_in), 32'd1);
        for (int k = 0; k < 63; k++) begin
            tick();
        end
        check("stall.e63", 32'(stall_err), 32'd0);
        tick();
        check("stall.e64",  32'(stall_err), 32'd1);
        check("stall.addr", 32'(addr_in),   32'h40);
        check("stall.data", 32'(data_in),   32'h41);
        check("stall.vld",  32'(valid_in),  32'd1);
        tick();
        check("stall.sticky", 32'(stall_err), 32'd1);
        clr_err = 1'b1; rcv_rdy = 1'b1;
        tick();
        clr_err = 1'b0; rcv_rdy = 1'b0;
        check("stall.clr", 32'(stall_err), 32'd0);
        check("stall.xfr", 32'(valid_in),  32'd0);

        // Reset mid-operation
        do_reset();
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_addr = 8'(i); wr_data = 8'(8'h50 + i);
            tick();
        end
        wr_en = 1'b0;
        check("mid.level", 32'(level),    32'd5);
        check("mid.valid", 32'(valid_in), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_state("mid.rst");
        wr_en = 1'b1; wr_addr = 8'h60; wr_data = 8'h61;
        tick();
        wr_en = 1'b0;
        check("mid.e1", 32'(valid_in), 32'd0);
        tick();
        check("mid.e2v", 32'(valid_in), 32'd1);
        check("mid.e2a", 32'(addr_in),  32'h60);
        check("mid.e2d", 32'(data_in),  32'h61);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
